frame_reader: RTL and testbench

FRAME_READER -- requirements
Module: frame_reader

---
 rtl/fb_pkg.sv | 13 +
 rtl/raster_counter.sv | 44 ++++
 rtl/frame_reader.sv | 117 +++++++++++
 tb/tb_frame_reader.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the frame reader: scan-out FSM state encoding and
// the default frame geometry (128 x 64 pixels, RGB444).
package fb_pkg;
  localparam int COL_W_DEF  = 7;
  localparam int ROW_W_DEF  = 6;
  localparam int LENGTH_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fr_state_e;
endpackage

// File: rtl/raster_counter.sv
// Raster-order column/row address counter. The column increments fastest and
// wraps to 0 while bumping the row; both wrap to 0 after the last address.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   clr_i         : force both counters to 0
//   en_i          : advance one raster position
//   col_o, row_o  : current position
//   col_wrap_o    : column is at its last value
//   last_o        : position is the final pixel of the frame
module raster_counter #(
  parameter int COL_W = 7,
  parameter int ROW_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             col_wrap_o,
  output logic             last_o
);
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;

  assign col_wrap_o = (col_q == {COL_W{1'b1}});
  assign last_o     = col_wrap_o && (row_q == {ROW_W{1'b1}});
  assign col_o      = col_q;
  assign row_o      = row_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      col_q <= '0;
      row_q <= '0;
    end else if (en_i) begin
      if (col_wrap_o) begin
        col_q <= '0;
        row_q <= row_q + 1'b1; // natural wrap to 0 after the last row
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/frame_reader.sv
// Double-buffered frame scan-out. On start, optionally swaps to the bank the
// renderer just finished, then reads every pixel in raster order from an
// asynchronous RAM and streams it out over a valid/ready handshake with a
// single output register.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : request one frame scan-out (accepted only when idle)
//   frame_ready     : back bank holds a completed frame (sampled on start)
//   read_addr       : RAM address {col,row}
//   read_bank       : bank being scanned
//   rdata           : RAM data for read_addr, same cycle
//   pix_data/valid  : registered pixel stream, ready from sink via pix_ready
//   pix_sol/pix_eof : pixel is column 0 / last pixel of frame
//   swap            : one-cycle pulse when read_bank toggles
//   busy            : scan in progress
module frame_reader
  import fb_pkg::*;
#(
  parameter int COL_W  = COL_W_DEF,
  parameter int ROW_W  = ROW_W_DEF,
  parameter int LENGTH = LENGTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   frame_ready,
  output logic [COL_W+ROW_W-1:0] read_addr,
  output logic                   read_bank,
  input  logic [LENGTH-1:0]      rdata,
  output logic [LENGTH-1:0]      pix_data,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic                   pix_sol,
  output logic                   pix_eof,
  output logic                   swap,
  output logic                   busy
);
  fr_state_e         state_q, state_d;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              col_wrap, last;
  logic              load_en, start_acc, xfer;
  logic [LENGTH-1:0] data_q;
  logic              valid_q, sol_q, eof_q, bank_q, swap_q;

  assign xfer = valid_q && pix_ready;

  raster_counter #(.COL_W(COL_W), .ROW_W(ROW_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (start_acc),
    .en_i       (load_en),
    .col_o      (col),
    .row_o      (row),
    .col_wrap_o (col_wrap),
    .last_o     (last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start)            state_d = ST_RUN;
      ST_RUN:   if (load_en && last)  state_d = ST_DRAIN;
      ST_DRAIN: if (xfer)             state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  // FSM outputs. The output register refills whenever it is empty or being
  // drained this cycle, so a held-high ready gives one pixel per cycle.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    start_acc = (state_q == ST_IDLE) && start;
    load_en   = (state_q == ST_RUN) && (!valid_q || pix_ready);
  end

  // Output register, bank select and swap pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sol_q   <= 1'b0;
      eof_q   <= 1'b0;
      bank_q  <= 1'b0;
      swap_q  <= 1'b0;
    end else begin
      swap_q <= start_acc && frame_ready;
      if (start_acc && frame_ready) bank_q <= ~bank_q;
      if (load_en) begin
        data_q  <= rdata;
        valid_q <= 1'b1;
        sol_q   <= (col == '0);
        eof_q   <= last;
      end else if (state_q == ST_DRAIN && xfer) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign read_addr = {col, row};
  assign read_bank = bank_q;
  assign pix_data  = data_q;
  assign pix_valid = valid_q;
  assign pix_sol   = sol_q;
  assign pix_eof   = eof_q;
  assign swap      = swap_q;

  logic unused_ok;
  assign unused_ok = col_wrap;
endmodule

// File: tb/tb_frame_reader.sv
module tb_frame_reader;
  localparam int COL_W  = 7;
  localparam int ROW_W  = 6;
  localparam int LENGTH = 12;
  localparam int NCOL   = 1 << COL_W;
  localparam int NROW   = 1 << ROW_W;
  localparam int NPIX   = NCOL * NROW;
  localparam int BUDGET = 40000;

  logic                   clk = 1'b0;
  logic                   rst, start, frame_ready, pix_ready;
  logic [COL_W+ROW_W-1:0] read_addr;
  logic                   read_bank;
  logic [LENGTH-1:0]      rdata, pix_data;
  logic                   pix_valid, pix_sol, pix_eof, swap, busy;

  logic [LENGTH-1:0] mem [2][NPIX];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rdata = mem[read_bank][read_addr];

  frame_reader #(.COL_W(COL_W), .ROW_W(ROW_W), .LENGTH(LENGTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .frame_ready (frame_ready),
    .read_addr   (read_addr),
    .read_bank   (read_bank),
    .rdata       (rdata),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_sol     (pix_sol),
    .pix_eof     (pix_eof),
    .swap        (swap),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {data,sol,eof} for the k-th pixel of a frame from bank b:
  // pixel k sits at column k%NCOL, row k/NCOL, RAM address col*NROW+row.
  function automatic logic [31:0] exp_pix(input int k, input bit b);
    int c, r;
    c = k % NCOL;
    r = k / NCOL;
    return {18'd0, mem[b][c*NROW + r], (c == 0), (k == NPIX-1)};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, pix_valid, 0);
    check({tag, "_data"},  pix_data,  0);
    check({tag, "_sol"},   pix_sol,   0);
    check({tag, "_eof"},   pix_eof,   0);
    check({tag, "_swap"},  swap,      0);
    check({tag, "_busy"},  busy,      0);
    check({tag, "_bank"},  read_bank, 0);
    check({tag, "_addr"},  read_addr, 0);
  endtask

  task automatic do_start(input bit fr, input bit exp_bank);
    @(negedge clk);
    start = 1'b1;
    frame_ready = fr;
    @(negedge clk);
    start = 1'b0;
    frame_ready = 1'b0;
    check("start_swap",  swap,      fr);
    check("start_bank",  read_bank, exp_bank);
    check("start_busy",  busy,      1);
    check("start_valid", pix_valid, 0);
    check("start_addr",  read_addr, 0);
  endtask

  // Sink one frame. poke_at: pulse start (with frame_ready) after that many
  // pixels. rst_at: assert reset coincident with that many pixels taken.
  task automatic scan(input bit exp_bank, input int rdy_pct, input int poke_at, input int rst_at);
    int k = 0;
    int cyc = 0;
    int nswap = 0;
    bit stall = 0;
    logic [31:0] held = '0;
    while (k < NPIX && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      frame_ready = 1'b0;
      if (cyc == 1) check("first_valid", pix_valid, 1);
      if (swap) nswap++;
      if (stall) check("hold", {17'd0, pix_valid, pix_data, pix_sol, pix_eof}, held);
      pix_ready = ($urandom_range(99) < rdy_pct);
      stall = pix_valid && !pix_ready;
      held  = {17'd0, pix_valid, pix_data, pix_sol, pix_eof};
      if (pix_valid && pix_ready) begin
        check("pix", {18'd0, pix_data, pix_sol, pix_eof}, exp_pix(k, exp_bank));
        k++;
        if (k == poke_at) begin
          start = 1'b1;
          frame_ready = 1'b1;
        end
        if (k == rst_at) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          pix_ready = 1'b0;
          check_reset_outputs("midrst");
          return;
        end
      end
    end
    check("frame_timeout", k, NPIX);
    @(negedge clk);
    pix_ready = 1'b0;
    check("end_busy",  busy,      0);
    check("end_valid", pix_valid, 0);
    check("end_addr",  read_addr, 0);
    check("end_bank",  read_bank, exp_bank);
    check("end_swaps", nswap,     0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    frame_ready = 1'b0;
    pix_ready = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < NPIX; a++)
        mem[b][a] = LENGTH'($urandom);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    // start held with reset must not be taken
    start = 1'b1;
    frame_ready = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_over_start");
    rst = 1'b0;
    start = 1'b0;
    frame_ready = 1'b0;

    // Full-rate frame from bank 0, no swap
    do_start(1'b0, 1'b0);
    scan(1'b0, 100, -1, -1);
    // Swap to bank 1
    do_start(1'b1, 1'b1);
    scan(1'b1, 100, -1, -1);
    // Random backpressure, bank stays 1
    do_start(1'b0, 1'b1);
    scan(1'b1, 50, -1, -1);
    // Start pulsed mid-frame is ignored, bank stays 1
    do_start(1'b0, 1'b1);
    scan(1'b1, 100, 100, -1);
    // Reset mid-frame, then a fresh frame from address 0 in bank 0
    do_start(1'b0, 1'b1);
    scan(1'b1, 100, -1, 4000);
    do_start(1'b0, 1'b0);
    scan(1'b0, 100, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
